// File: rtl/pt2272_output_stage_if.sv
// Decoder-to-output-stage bus: decoded nibble and data-valid in, confirmed pins out.
//   d_in      decoded data nibble from the decoder
//   dv_in     decoder data-valid level
//   d_out     confirmed output data
//   vt        valid transmission flag
//   new_data  one-cycle pulse when d_out is loaded
// master = decoder side, slave = output stage.
interface pt2272_output_stage_if;
  logic [3:0] d_in;
  logic       dv_in;
  logic [3:0] d_out;
  logic       vt;
  logic       new_data;

  modport master (
    output d_in,
    output dv_in,
    input  d_out,
    input  vt,
    input  new_data
  );

  modport slave (
    input  d_in,
    input  dv_in,
    output d_out,
    output vt,
    output new_data
  );
endinterface

// File: rtl/pt2272_output_stage.sv
// PT2272 output stage: confirms consecutive identical frames, drives d_out/vt/new_data.
//   osc_clk  12 kHz oscillator clock, rising edge
//   reset    asynchronous, active-high
//   bus      slave side of pt2272_output_stage_if (d_in, dv_in -> d_out, vt, new_data)
// CONFIRM_FRAMES matching frames raise vt; HOLD_CYCLES of silence drop it.
// LATCH_MODE=1 keeps d_out at its last confirmed value after vt drops.
module pt2272_output_stage #(
  parameter int unsigned CONFIRM_FRAMES = 2,
  parameter int unsigned HOLD_CYCLES    = 1536,
  parameter bit          LATCH_MODE     = 1'b0
) (
  input  logic                  osc_clk,
  input  logic                  reset,
  pt2272_output_stage_if.slave  bus
);

  localparam int unsigned SIL_W   = 12;
  localparam int unsigned MATCH_W = 3;
  localparam logic [SIL_W-1:0]   SIL_MAX    = SIL_W'(HOLD_CYCLES - 1);
  localparam logic [MATCH_W-1:0] MATCH_GOAL = MATCH_W'(CONFIRM_FRAMES);

  typedef enum logic [1:0] {IDLE, CONFIRM, VALID} state_t;

  state_t             state;
  logic               dv_q;
  logic [3:0]         cand;
  logic [MATCH_W-1:0] match_cnt;
  logic [SIL_W-1:0]   silence_cnt;
  logic [3:0]         d_out_q;
  logic               vt_q;
  logic               new_data_q;

  logic               frame_evt;
  logic               at_limit;
  logic               timeout;
  logic               cand_hit;
  logic [MATCH_W-1:0] match_nxt;

  // Only the rising edge of dv_in marks a frame; a frame beats a coincident timeout.
  assign frame_evt = bus.dv_in & ~dv_q;
  assign at_limit  = (silence_cnt == SIL_MAX);
  assign timeout   = at_limit & ~frame_evt;
  assign cand_hit  = (bus.d_in == cand);
  assign match_nxt = match_cnt + MATCH_W'(1);

  // Confirmation FSM with registered outputs.
  always_ff @(posedge osc_clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      dv_q        <= 1'b0;
      cand        <= 4'd0;
      match_cnt   <= '0;
      silence_cnt <= '0;
      d_out_q     <= 4'd0;
      vt_q        <= 1'b0;
      new_data_q  <= 1'b0;
    end else begin
      dv_q       <= bus.dv_in;
      new_data_q <= 1'b0;

      // Silence counter saturates while a transmission is tracked; frames restart it.
      if (frame_evt) begin
        silence_cnt <= '0;
      end else if ((state != IDLE) && !at_limit) begin
        silence_cnt <= silence_cnt + SIL_W'(1);
      end

      case (state)
        IDLE: begin
          silence_cnt <= '0;
          if (frame_evt) begin
            cand      <= bus.d_in;
            match_cnt <= MATCH_W'(1);
            if (CONFIRM_FRAMES == 1) begin
              d_out_q    <= bus.d_in;
              vt_q       <= 1'b1;
              new_data_q <= 1'b1;
              state      <= VALID;
            end else begin
              state <= CONFIRM;
            end
          end
        end

        CONFIRM: begin
          if (frame_evt) begin
            if (cand_hit) begin
              match_cnt <= match_nxt;
              if (match_nxt == MATCH_GOAL) begin
                d_out_q    <= cand;
                vt_q       <= 1'b1;
                new_data_q <= 1'b1;
                state      <= VALID;
              end
            end else begin
              cand      <= bus.d_in;
              match_cnt <= MATCH_W'(1);
            end
          end else if (timeout) begin
            match_cnt   <= '0;
            silence_cnt <= '0;
            state       <= IDLE;
          end
        end

        VALID: begin
          if (frame_evt) begin
            // A matching frame only refreshes the silence counter.
            if (!cand_hit) begin
              vt_q      <= 1'b0;
              cand      <= bus.d_in;
              match_cnt <= MATCH_W'(1);
              state     <= CONFIRM;
              if (!LATCH_MODE) d_out_q <= 4'd0;
            end
          end else if (timeout) begin
            vt_q        <= 1'b0;
            match_cnt   <= '0;
            silence_cnt <= '0;
            state       <= IDLE;
            if (!LATCH_MODE) d_out_q <= 4'd0;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.d_out    = d_out_q;
  assign bus.vt       = vt_q;
  assign bus.new_data = new_data_q;

endmodule

// File: tb/tb_pt2272_output_stage.sv
// Directed bench: one momentary and one latched instance share the same stimulus.
module tb_pt2272_output_stage;

  logic       osc_clk = 1'b0;
  logic       reset   = 1'b1;
  logic [3:0] d_in    = 4'd0;
  logic       dv_in   = 1'b0;

  int checks = 0;
  int errors = 0;

  pt2272_output_stage_if if0 ();
  pt2272_output_stage_if if1 ();

  assign if0.d_in  = d_in;
  assign if0.dv_in = dv_in;
  assign if1.d_in  = d_in;
  assign if1.dv_in = dv_in;

  pt2272_output_stage #(.CONFIRM_FRAMES(2), .HOLD_CYCLES(1536), .LATCH_MODE(1'b0)) dut0 (
    .osc_clk (osc_clk),
    .reset   (reset),
    .bus     (if0.slave)
  );

  pt2272_output_stage #(.CONFIRM_FRAMES(2), .HOLD_CYCLES(1536), .LATCH_MODE(1'b1)) dut1 (
    .osc_clk (osc_clk),
    .reset   (reset),
    .bus     (if1.slave)
  );

  always #5 osc_clk = ~osc_clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks both instances; d0_e is the momentary d_out, d1_e the latched d_out.
  task automatic chk_all(input string tag, input logic vt_e, input logic nd_e,
                         input logic [3:0] d0_e, input logic [3:0] d1_e);
    chk({tag, " vt0"},  4'(if0.vt),       4'(vt_e));
    chk({tag, " nd0"},  4'(if0.new_data), 4'(nd_e));
    chk({tag, " dout0"}, if0.d_out,       d0_e);
    chk({tag, " vt1"},  4'(if1.vt),       4'(vt_e));
    chk({tag, " nd1"},  4'(if1.new_data), 4'(nd_e));
    chk({tag, " dout1"}, if1.d_out,       d1_e);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge osc_clk);
    #1;
  endtask

  // Raise dv_in with nib; returns just after the edge that samples the frame event.
  task automatic frame(input logic [3:0] nib);
    d_in  = nib;
    dv_in = 1'b1;
    @(posedge osc_clk);
    #1;
  endtask

  // dv_in high 3 cycles in total, then low; returns one cycle before the edge
  // that lies 'total' cycles after the last frame event.
  task automatic gap(input int total);
    wait_cyc(2);
    dv_in = 1'b0;
    wait_cyc(total - 3);
  endtask

  initial begin
    // Reset state
    wait_cyc(2);
    chk_all("reset", 1'b0, 1'b0, 4'h0, 4'h0);
    reset = 1'b0;

    // Reset mid-CONFIRM discards the partial match
    frame(4'hA);
    chk_all("first_a", 1'b0, 1'b0, 4'h0, 4'h0);
    wait_cyc(2);
    dv_in = 1'b0;
    wait_cyc(5);
    #2 reset = 1'b1;
    #1 chk_all("async_rst_confirm", 1'b0, 1'b0, 4'h0, 4'h0);
    @(posedge osc_clk);
    #1 reset = 1'b0;
    wait_cyc(3);
    frame(4'hA);
    chk_all("after_rst_single", 1'b0, 1'b0, 4'h0, 4'h0);

    // Basic confirmation: 5 twice, 512 cycles apart (first 5 replaces candidate A)
    gap(512);
    frame(4'h5);
    chk_all("basic_first", 1'b0, 1'b0, 4'h0, 4'h0);
    gap(512);
    frame(4'h5);
    chk_all("basic_confirm", 1'b1, 1'b1, 4'h5, 4'h5);
    wait_cyc(1);
    chk_all("basic_pulse_end", 1'b1, 1'b0, 4'h5, 4'h5);
    wait_cyc(1);
    chk_all("basic_held_hi", 1'b1, 1'b0, 4'h5, 4'h5);
    wait_cyc(507);
    frame(4'h5);
    chk_all("basic_keepalive", 1'b1, 1'b0, 4'h5, 4'h5);

    // Mismatch restart: 3, 6, 6
    gap(512);
    frame(4'h3);
    chk_all("mm_3", 1'b0, 1'b0, 4'h0, 4'h5);
    gap(512);
    frame(4'h6);
    chk_all("mm_6a", 1'b0, 1'b0, 4'h0, 4'h5);
    gap(512);
    frame(4'h6);
    chk_all("mm_6b", 1'b1, 1'b1, 4'h6, 4'h6);

    // Confirm 9, then silence: drop exactly 1536 cycles after the last frame event
    gap(512);
    frame(4'h9);
    chk_all("to_9a", 1'b0, 1'b0, 4'h0, 4'h6);
    gap(512);
    frame(4'h9);
    chk_all("to_9b", 1'b1, 1'b1, 4'h9, 4'h9);
    wait_cyc(2);
    dv_in = 1'b0;
    wait_cyc(1533);
    chk_all("to_1535", 1'b1, 1'b0, 4'h9, 4'h9);
    wait_cyc(1);
    chk_all("to_1536", 1'b0, 1'b0, 4'h0, 4'h9);

    // Confirm C; a frame on the silence_cnt==1535 cycle keeps vt
    wait_cyc(20);
    frame(4'hC);
    chk_all("c_first", 1'b0, 1'b0, 4'h0, 4'h9);
    gap(512);
    frame(4'hC);
    chk_all("c_confirm", 1'b1, 1'b1, 4'hC, 4'hC);
    gap(1536);
    frame(4'hC);
    chk_all("boundary_1535", 1'b1, 1'b0, 4'hC, 4'hC);

    // Latched timeout holds C, then confirm 1
    wait_cyc(2);
    dv_in = 1'b0;
    wait_cyc(1534);
    chk_all("c_timeout", 1'b0, 1'b0, 4'h0, 4'hC);
    wait_cyc(10);
    frame(4'h1);
    chk_all("one_first", 1'b0, 1'b0, 4'h0, 4'hC);
    gap(512);
    frame(4'h1);
    chk_all("one_confirm", 1'b1, 1'b1, 4'h1, 4'h1);

    // dv_in held 2000 cycles is one frame; it times out into IDLE
    gap(512);
    frame(4'h7);
    chk_all("held_rise", 1'b0, 1'b0, 4'h0, 4'h1);
    wait_cyc(1000);
    chk_all("held_1000", 1'b0, 1'b0, 4'h0, 4'h1);
    wait_cyc(999);
    dv_in = 1'b0;
    wait_cyc(4);
    frame(4'h7);
    chk_all("held_refirst", 1'b0, 1'b0, 4'h0, 4'h1);
    gap(512);
    frame(4'h7);
    chk_all("held_confirm", 1'b1, 1'b1, 4'h7, 4'h7);

    // Asynchronous reset while VALID clears outputs without a clock edge
    wait_cyc(3);
    #2 reset = 1'b1;
    #1 chk_all("async_rst_valid", 1'b0, 1'b0, 4'h0, 4'h0);
    wait_cyc(2);
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pt2272_output_stage.md
Name: pt2272_output_stage

Overview:
- Downstream stage of the PT2272 decoder. Consumes its registered data nibble and data-valid level, and confirms that consecutive received frames match.
- Drives the final data pins and the VT (valid transmission) pin.
- Supports momentary (M-type) and latched (L-type) output behaviour.
- Runs in the 12 kHz oscillator domain shared with the decoder.

Parameters:
- CONFIRM_FRAMES, 2, consecutive identical frames required before VT asserts (legal range 1..7).
- HOLD_CYCLES, 1536, osc_clk cycles without a frame event before the transmission is declared lost (about 3 frames; legal range 2..4095).
- LATCH_MODE, 0, 0 = momentary: outputs clear when VT drops. 1 = latched: d_out holds its last confirmed value.

Ports:
- osc_clk  in  1  12 kHz oscillator clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high.
- d_in  in  4  decoded data nibble from the decoder.
- dv_in  in  1  decoder data-valid level; may stay high for several cycles per frame.
- d_out  out  4  confirmed output data.
- vt  out  1  valid transmission: high while confirmed frames keep arriving.
- new_data  out  1  one-cycle pulse when d_out is loaded with a confirmed value.

Behaviour:
- Reset is asynchronous, active-high, clock osc_clk. While reset is high: d_out=0, vt=0, new_data=0, dv_q=0, cand=0, match_cnt=0, silence_cnt=0, state=IDLE. A reset mid-frame discards all partial confirmation.
- Frame event: frame_evt = dv_in & ~dv_q, where dv_q is dv_in registered every cycle.
  - Only the rising edge of dv_in counts. A dv_in held high counts as one frame.
  - d_in is sampled on the same edge as frame_evt.
- silence_cnt (12 bits):
  - Cleared on every frame_evt and on every state change into CONFIRM.
  - Otherwise increments in CONFIRM and VALID, saturating at HOLD_CYCLES-1.
  - Timeout = (silence_cnt == HOLD_CYCLES-1) with no frame_evt in that cycle.
  - If frame_evt and timeout coincide, frame_evt wins.
- match_cnt is 3 bits. cand holds the candidate nibble.
- State IDLE:
  - On frame_evt: cand<=d_in, match_cnt<=1.
  - If CONFIRM_FRAMES==1, perform the VALID entry actions directly; otherwise go to CONFIRM.
- State CONFIRM:
  - frame_evt with d_in==cand: match_cnt++. If the new count equals CONFIRM_FRAMES, go to VALID.
  - frame_evt with d_in!=cand: cand<=d_in, match_cnt<=1, stay in CONFIRM.
  - Timeout: go to IDLE, match_cnt<=0.
- VALID entry actions (all on one edge):
  - d_out<=cand, vt<=1, new_data<=1 for exactly one cycle.
  - Latency: outputs are visible after the osc_clk edge that samples the confirming frame_evt (0 extra cycles).
- State VALID:
  - frame_evt with d_in==cand: clear silence_cnt only; outputs unchanged; no new_data pulse.
  - frame_evt with d_in!=cand: vt<=0; cand<=d_in; match_cnt<=1; go to CONFIRM. d_out<=0 if LATCH_MODE=0, otherwise held.
  - Timeout: vt<=0; go to IDLE; match_cnt<=0. d_out<=0 if LATCH_MODE=0, otherwise held.
- In latched mode, d_out changes only on VALID entry; new_data pulses even if the value equals the previous d_out.
- new_data is 0 in every cycle other than VALID entry.
- vt is 1 only in state VALID.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset check: assert reset mid-CONFIRM after one frame of d_in=4'hA. Required: d_out=0, vt=0, new_data=0 immediately, asynchronously. After release, a single frame does not raise vt.
- Basic confirmation (defaults): two dv_in pulses 512 cycles apart, d_in=4'h5, dv_in high 3 cycles each. Required: vt=1 and d_out=5 on the edge sampling the second rise; new_data high exactly 1 cycle; vt stays high while pulses continue.
- Mismatch restart: frames 4'h3, 4'h6, 4'h6. Required: vt stays 0 after the second frame; vt=1 with d_out=6 after the third frame.
- Timeout, momentary (LATCH_MODE=0): confirm 4'h9, then stop pulses. Required: vt=0 and d_out=0 exactly HOLD_CYCLES=1536 cycles after the last frame_evt.
- Timeout and change, latched (LATCH_MODE=1): after confirmed 4'hC, stop pulses. Required: vt=0 and d_out holds C. Then confirm 4'h1. Required: d_out=1 and a new_data pulse.
- Boundary: a frame_evt landing on the silence_cnt==1535 cycle keeps vt=1. Also, dv_in held high for 2000 cycles counts as one frame: vt does not rise with CONFIRM_FRAMES=2, and the first timeout is at cycle 1536.
